// File: rtl/seg_disp_pkg.sv
// Shared types, constants and encode helpers for the serial 7-segment display arbiter.
package seg_disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2,
    LATCH = 2'd3
  } disp_state_e;

  localparam int SEG_FRAME_W = 64;

  // Active-low segment patterns for hex digits 0..F; bit 7 (the dot) is carried as 1.
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  function automatic logic [7:0] encode_nibble(input logic [3:0] nib, input logic dot);
    logic [7:0] pattern;
    pattern = SEG_TABLE[nib];
    return {~dot, pattern[6:0]};
  endfunction

  // Digit k lands in frame byte k, so digit 7 is shifted out first.
  function automatic logic [SEG_FRAME_W-1:0] encode_word(input logic [31:0] word,
                                                         input logic [7:0] dots);
    logic [SEG_FRAME_W-1:0] frame;
    frame = '0;
    for (int k = 0; k < 8; k++) begin
      frame[8*k +: 8] = encode_nibble(word[4*k +: 4], dots[k]);
    end
    return frame;
  endfunction

endpackage

// File: rtl/seg_disp_arbiter_if.sv
// Requester-side handshake bundle: valid/data/dot in, one-hot ready and last winner out.
interface seg_disp_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ*8-1:0]      req_dot;
  logic [NUM_REQ-1:0]        req_ready;
  logic [2:0]                grant_id;

  modport master (output req_valid, req_data, req_dot, input req_ready, grant_id);
  modport slave  (input req_valid, req_data, req_dot, output req_ready, grant_id);
endinterface

// File: rtl/seg_rr_arb.sv
// Round-robin pick: first asserted valid strictly after the pointer, wrapping around.
module seg_rr_arb #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [2:0]         ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [2:0]         idx,
  output logic               any
);

  // Scan offsets 1..NUM_REQ from the pointer; the first hit wins.
  always_comb begin
    int cand;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = (int'(ptr) + off) % NUM_REQ;
      if (!any && valid[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = 3'(cand);
      end
    end
  end

endmodule

// File: rtl/seg_disp_arbiter.sv
// Round-robin display arbiter: accepts one word, then clears the panel, shifts 64
// encoded bits MSB first on SEGCLK and pulses the enable before accepting again.
module seg_disp_arbiter
  import seg_disp_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32,
  parameter int CLK_DIV = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  seg_disp_arbiter_if.slave     bus,
  output logic                  busy,
  output logic                  SEGCLK,
  output logic                  SEGCLR,
  output logic                  SEGDT,
  output logic                  SEGEN
);

  localparam int              PH_W    = $clog2(CLK_DIV) + 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLK_DIV - 1);

  disp_state_e            state, state_nx;
  logic [PH_W-1:0]        phase;
  logic                   hi;
  logic [5:0]             bit_idx;
  logic [2:0]             ptr;
  logic                   shown;
  logic [SEG_FRAME_W-1:0] frame;

  logic [NUM_REQ-1:0]     pick;
  logic [2:0]             pick_idx;
  logic                   pick_any;
  logic                   phase_end;
  logic                   accept;
  logic [DATA_W-1:0]      sel_data;
  logic [7:0]             sel_dot;

  seg_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .valid (bus.req_valid),
    .ptr   (ptr),
    .grant (pick),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign phase_end = (phase == PH_LAST);
  assign accept    = (state == IDLE) && pick_any;
  assign sel_data  = bus.req_data[int'(pick_idx)*DATA_W +: DATA_W];
  assign sel_dot   = bus.req_dot[int'(pick_idx)*8 +: 8];

  // Ready is gated by rstn so it reads 0 while reset holds the FSM in IDLE.
  assign bus.req_ready = (accept && rstn) ? pick : '0;

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state: each non-idle state lasts whole CLK_DIV periods; SHIFT ends after bit 0 high phase.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (pick_any) state_nx = CLEAR;
      CLEAR:   if (phase_end) state_nx = SHIFT;
      SHIFT:   if (phase_end && hi && (bit_idx == 6'd0)) state_nx = LATCH;
      LATCH:   if (phase_end) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Phase, half-period and bit counters that pace the serial clock.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      phase   <= '0;
      hi      <= 1'b0;
      bit_idx <= 6'd63;
    end else begin
      phase <= ((state == IDLE) || phase_end) ? '0 : phase + PH_W'(1);
      if (state == SHIFT) begin
        if (phase_end) begin
          hi <= ~hi;
          if (hi) bit_idx <= bit_idx - 6'd1;
        end
      end else begin
        hi      <= 1'b0;
        bit_idx <= 6'd63;
      end
    end
  end

  // Arbitration bookkeeping and the sticky "a frame has been displayed" flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr          <= 3'(NUM_REQ - 1);
      bus.grant_id <= 3'd0;
      shown        <= 1'b0;
    end else begin
      if (accept) begin
        ptr          <= pick_idx;
        bus.grant_id <= pick_idx;
      end
      if ((state == LATCH) && phase_end) shown <= 1'b1;
    end
  end

  // Encoded frame captured on the accepting edge; only read while SHIFT is active.
  always_ff @(posedge clk) begin
    if (accept) frame <= encode_word(sel_data, sel_dot);
  end

  // Panel outputs decoded from the FSM so an async reset forces them immediately.
  always_comb begin
    busy   = (state != IDLE);
    SEGCLR = (state != CLEAR);
    SEGCLK = (state == SHIFT) && hi;
    SEGDT  = (state == SHIFT) && frame[bit_idx];
    SEGEN  = (state == LATCH) || ((state == IDLE) && shown);
  end

endmodule

// File: tb/tb_seg_disp_arbiter.sv
// Directed bench: two arbiter instances (CLK_DIV=2 and CLK_DIV=1), frames captured on SEGCLK.
module tb_seg_disp_arbiter;

  logic clk;
  logic rstn;
  int   total = 0;
  int   bad   = 0;

  seg_disp_arbiter_if #(.NUM_REQ(2), .DATA_W(32)) a_if ();
  seg_disp_arbiter_if #(.NUM_REQ(2), .DATA_W(32)) b_if ();

  logic a_busy, a_segclk, a_segclr, a_segdt, a_segen;
  logic b_busy, b_segclk, b_segclr, b_segdt, b_segen;

  seg_disp_arbiter #(.NUM_REQ(2), .DATA_W(32), .CLK_DIV(2)) dut_a (
    .clk(clk), .rstn(rstn), .bus(a_if), .busy(a_busy),
    .SEGCLK(a_segclk), .SEGCLR(a_segclr), .SEGDT(a_segdt), .SEGEN(a_segen)
  );

  seg_disp_arbiter #(.NUM_REQ(2), .DATA_W(32), .CLK_DIV(1)) dut_b (
    .clk(clk), .rstn(rstn), .bus(b_if), .busy(b_busy),
    .SEGCLK(b_segclk), .SEGCLR(b_segclr), .SEGDT(b_segdt), .SEGEN(b_segen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] a_cap   = '0;
  int          a_edges = 0;
  logic [63:0] b_cap   = '0;
  int          b_edges = 0;

  always @(posedge a_segclk) begin
    a_cap   = {a_cap[62:0], a_segdt};
    a_edges = a_edges + 1;
  end

  always @(posedge b_segclk) begin
    b_cap   = {b_cap[62:0], b_segdt};
    b_edges = b_edges + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after the accepting edge of dut_a; follows the frame until IDLE.
  task automatic a_frame(input string tag, input logic [63:0] exp_frame,
                         input int inject_at, input logic [1:0] inject_valid);
    int base, clr_lo, en_at, idle_at, viol;
    base = a_edges; clr_lo = 0; en_at = -1; idle_at = -1; viol = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (c == inject_at) a_if.req_valid = inject_valid;
      if (!a_segclr) clr_lo++;
      if (a_segen && en_at < 0) en_at = c;
      if (a_busy && a_if.req_ready != 2'b00) viol++;
      if (!a_busy) begin
        idle_at = c;
        break;
      end
    end
    chk({tag, "_idle_at"}, 64'(idle_at), 64'd260);
    chk({tag, "_en_at"},   64'(en_at),   64'd258);
    chk({tag, "_clr_lo"},  64'(clr_lo),  64'd2);
    chk({tag, "_ready_busy"}, 64'(viol), 64'd0);
    chk({tag, "_edges"}, 64'(a_edges - base), 64'd64);
    chk({tag, "_frame"}, a_cap, exp_frame);
  endtask

  initial begin
    int hi_cnt, clr_cnt, idle_at, base;
    rstn = 1'b0;
    a_if.req_valid = '0; a_if.req_data = '0; a_if.req_dot = '0;
    b_if.req_valid = '0; b_if.req_data = '0; b_if.req_dot = '0;

    repeat (2) @(negedge clk);
    chk("rst_ready",  64'(a_if.req_ready), 64'd0);
    chk("rst_grant",  64'(a_if.grant_id),  64'd0);
    chk("rst_busy",   64'(a_busy),   64'd0);
    chk("rst_segclk", 64'(a_segclk), 64'd0);
    chk("rst_segclr", 64'(a_segclr), 64'd1);
    chk("rst_segdt",  64'(a_segdt),  64'd0);
    chk("rst_segen",  64'(a_segen),  64'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("idle_noreq_ready", 64'(a_if.req_ready), 64'd0);

    // Single word from req0.
    a_if.req_data[31:0] = 32'h8000_0000;
    a_if.req_valid = 2'b01;
    #1 chk("t1_ready", 64'(a_if.req_ready), 64'd1);
    @(posedge clk);
    a_frame("t1", 64'h80C0_C0C0_C0C0_C0C0, 0, 2'b00);
    chk("t1_grant", 64'(a_if.grant_id), 64'd0);
    chk("t1_segen_hold", 64'(a_segen), 64'd1);

    // Both held valid: strict alternation starting after last winner 0.
    a_if.req_data = {32'h2222_2222, 32'h1111_1111};
    a_if.req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1 chk("t2_ready", 64'(a_if.req_ready), (k % 2 == 0) ? 64'd2 : 64'd1);
      @(posedge clk);
      a_frame("t2", (k % 2 == 0) ? 64'hA4A4_A4A4_A4A4_A4A4 : 64'hF9F9_F9F9_F9F9_F9F9,
              (k == 3) ? 0 : -1, 2'b00);
      chk("t2_grant", 64'(a_if.grant_id), (k % 2 == 0) ? 64'd1 : 64'd0);
    end

    // req1 hex F with digit-0 dot lit.
    a_if.req_data[63:32] = 32'h0000_000F;
    a_if.req_dot[15:8]   = 8'h01;
    a_if.req_valid = 2'b10;
    #1 chk("t3_ready", 64'(a_if.req_ready), 64'd2);
    @(posedge clk);
    a_frame("t3", 64'hC0C0_C0C0_C0C0_C00E, 0, 2'b00);
    chk("t3_last_byte", 64'(a_cap[7:0]), 64'h0E);
    chk("t3_grant", 64'(a_if.grant_id), 64'd1);

    // req1 arrives mid-frame and is served on the first IDLE cycle.
    a_if.req_data[63:32] = 32'h1234_5678;
    a_if.req_dot[15:8]   = 8'h80;
    a_if.req_valid = 2'b01;
    #1 chk("t4_ready", 64'(a_if.req_ready), 64'd1);
    @(posedge clk);
    a_frame("t4a", 64'hF9F9_F9F9_F9F9_F9F9, 50, 2'b10);
    #1 chk("t4_ready_idle", 64'(a_if.req_ready), 64'd2);
    @(posedge clk);
    a_frame("t4b", 64'h79A4_B099_9282_F880, 0, 2'b00);
    chk("t4_grant", 64'(a_if.grant_id), 64'd1);

    // CLK_DIV=1 instance.
    b_if.req_data[31:0] = 32'h7654_3210;
    b_if.req_valid = 2'b01;
    #1 chk("t5_ready", 64'(b_if.req_ready), 64'd1);
    @(posedge clk);
    base = b_edges; hi_cnt = 0; clr_cnt = 0; idle_at = -1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (c == 0) b_if.req_valid = 2'b00;
      if (b_segclk) hi_cnt++;
      if (!b_segclr) clr_cnt++;
      if (!b_busy) begin
        idle_at = c;
        break;
      end
    end
    chk("t5_idle_at", 64'(idle_at), 64'd130);
    chk("t5_hi_cycles", 64'(hi_cnt), 64'd64);
    chk("t5_clr_lo", 64'(clr_cnt), 64'd1);
    chk("t5_edges", 64'(b_edges - base), 64'd64);
    chk("t5_frame", b_cap, 64'hF882_9299_B0A4_F9C0);
    chk("t5_segen", 64'(b_segen), 64'd1);

    // Async reset in the middle of SHIFT.
    a_if.req_data[31:0] = 32'hDEAD_BEEF;
    a_if.req_dot[7:0]   = 8'h00;
    a_if.req_valid = 2'b01;
    #1 chk("t6_ready", 64'(a_if.req_ready), 64'd1);
    @(posedge clk);
    base = a_edges;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (c == 0) a_if.req_valid = 2'b00;
      if (a_edges - base >= 34) break;
    end
    chk("t6_reached_bit30", 64'(a_edges - base >= 34), 64'd1);
    a_if.req_valid = 2'b11;
    rstn = 1'b0;
    #1;
    chk("t6_segclk", 64'(a_segclk), 64'd0);
    chk("t6_segdt",  64'(a_segdt),  64'd0);
    chk("t6_segen",  64'(a_segen),  64'd0);
    chk("t6_busy",   64'(a_busy),   64'd0);
    chk("t6_segclr", 64'(a_segclr), 64'd1);
    chk("t6_ready_in_rst", 64'(a_if.req_ready), 64'd0);
    chk("t6_grant_rst", 64'(a_if.grant_id), 64'd0);
    chk("t6_b_segen", 64'(b_segen), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    #1 chk("t6_ready_after", 64'(a_if.req_ready), 64'd1);
    @(posedge clk);
    a_frame("t6", 64'hA186_88A1_8386_868E, 0, 2'b00);
    chk("t6_grant", 64'(a_if.grant_id), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
